spi_crypto_slave: RTL
=====================

SPI_CRYPTO_SLAVE -- requirements
Module: spi_crypto_slave

Interface
REQ-001 SHALL have parameter BLOCK_W, default 128, meaning cipher block width in bits.
REQ-002 SHALL have parameter KEY_MAX_W, default 256, meaning widest key bus in bits.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser depth on sclk, cs_n and mosi.
REQ-004 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 sclk  input  1  SPI serial clock, asynchronous; frequency at most clk/4.
REQ-007 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-008 mosi  input  1  SPI serial data in.
REQ-009 miso  output  1  SPI serial data out.
REQ-010 miso_oe  output  1  miso drive enable; 1 while synchronised cs_n is low.
REQ-011 core_start  output  1  one-clk pulse launching the cipher core.
REQ-012 core_enc  output  1  1 = encrypt, 0 = decrypt.
REQ-013 core_nk  output  2  key-length code: 00 Nk4, 01 Nk6, 10 Nk8.
REQ-014 core_data  output  BLOCK_W  block to the core.
REQ-015 core_key  output  KEY_MAX_W  key, left-justified, unused LSBs zero.
REQ-016 core_done  input  1  one-clk pulse; core_result valid in that cycle.
REQ-017 core_result  input  BLOCK_W  cipher core output.
REQ-018 busy  output  1  high from frame start until return to IDLE.
REQ-019 err  output  1  sticky header error; cleared at next frame start.

Function
REQ-020 SHALL use SPI mode 0: sample mosi on synchronised sclk rising edge, update miso on falling edge; all bits MSB first.
REQ-021 Frame SHALL be: 8-bit header, BLOCK_W data bits, 32*Nk key bits, then read phase.
REQ-022 Header: bit7 = enc/dec, bits6:5 = Nk code, bits4:0 reserved and ignored.
REQ-023 States SHALL be IDLE, HDR, DATA, KEY, START, WAIT, SEND, ERROR, DRAIN.
REQ-024 IDLE->HDR on cs_n falling; clear bit counter and err.
REQ-025 HDR->DATA after 8 bits; Nk code 11 -> ERROR, err=1.
REQ-026 DATA->KEY after BLOCK_W bits; KEY->START after 128/192/256 bits for Nk4/6/8.
REQ-027 START SHALL hold core_start=1 for exactly one clk, then enter WAIT; core_* buses stable from START until core_done.
REQ-028 In WAIT and ERROR, miso SHALL drive 0 on every falling edge.
REQ-029 On core_done in WAIT, result latched; at next falling edge miso SHALL drive ready bit 1, then BLOCK_W result bits on following falling edges.
REQ-030 SEND->IDLE after last result bit and cs_n rising; extra sclk pulses in SEND shift out 0.
REQ-031 cs_n rising in HDR/DATA/KEY/ERROR/SEND SHALL abort to IDLE without core_start.
REQ-032 cs_n rising in WAIT SHALL enter DRAIN; busy stays 1 until core_done, which is discarded, then IDLE.
REQ-033 core_done outside WAIT/DRAIN SHALL be ignored.
REQ-034 Bit counter SHALL be 9 bits, saturating-free, reset at each phase transition.
REQ-035 cs_n falling while in DRAIN SHALL be ignored until IDLE is reached.

Reset
REQ-036 rst low at any clk edge SHALL force IDLE, counters 0, miso 0, miso_oe 0, core_start 0, core_enc 0, core_nk 00, core_data 0, core_key 0, busy 0, err 0, synchronisers 1 for cs_n/sclk idle.
REQ-037 Reset mid-frame SHALL discard partial frame; a later core_done SHALL be ignored.

Structure
REQ-038 Package spi_crypto_pkg SHALL hold state enum, Nk codes, key-length constants, header bit positions.
REQ-039 Sub-module spi_sync_edge SHALL implement SYNC_STAGES synchroniser plus rising/falling edge pulses; instantiated for sclk and cs_n.

Verification
REQ-040 Header 0x80, data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, core model latency 5 -> core_start once, core_nk 00, core_enc 1, miso ready bit then 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-041 Header 0x40, data 8ea2b7ca516745bfeafc49904b496089, key 00..1f -> core_nk 10, core_enc 0, result 00112233445566778899aabbccddeeff.
REQ-042 Header 0xE0 -> err=1 after bit 8, no core_start, miso 0 throughout; next frame clears err.
REQ-043 cs_n raised at data bit 50 -> IDLE, busy 0, no core_start; next full frame correct.
REQ-044 cs_n raised in WAIT, core latency 20 -> busy 1 until core_done, no ready bit; new frame accepted after.
REQ-045 rst low during KEY bit 100 -> all outputs at reset values next clk; stale core_done ignored.

Source files
------------

// File: rtl/spi_crypto_pkg.sv
// rtl/spi_crypto_pkg.sv - shared states, key-length codes and header layout for the SPI crypto slave
package spi_crypto_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_KEY,
        ST_START,
        ST_WAIT,
        ST_SEND,
        ST_ERROR,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] NK4    = 2'b00;
    localparam logic [1:0] NK6    = 2'b01;
    localparam logic [1:0] NK8    = 2'b10;
    localparam logic [1:0] NK_BAD = 2'b11;

    localparam int KEY_BITS_NK4 = 128;
    localparam int KEY_BITS_NK6 = 192;
    localparam int KEY_BITS_NK8 = 256;

    localparam int HDR_W       = 8;
    localparam int HDR_ENC_BIT = 7;
    localparam int HDR_NK_LSB  = 5;
    // Only the leading header bits down to the Nk field carry meaning.
    localparam int HDR_KEEP    = HDR_W - HDR_NK_LSB;

    function automatic int key_bits(input logic [1:0] nk);
        case (nk)
            NK6:     return KEY_BITS_NK6;
            NK8:     return KEY_BITS_NK8;
            default: return KEY_BITS_NK4;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser with rising/falling edge pulses
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_level;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= SYNC_STAGES'({r_sync, i_async});
            r_prev <= w_level;
        end
    end

    assign w_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/spi_crypto_slave.sv
// rtl/spi_crypto_slave.sv - SPI mode-0 slave that frames a cipher request and returns the core result
module spi_crypto_slave
    import spi_crypto_pkg::*;
#(
    parameter int BLOCK_W     = 128,
    parameter int KEY_MAX_W   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic                 core_start,
    output logic                 core_enc,
    output logic [1:0]           core_nk,
    output logic [BLOCK_W-1:0]   core_data,
    output logic [KEY_MAX_W-1:0] core_key,
    input  logic                 core_done,
    input  logic [BLOCK_W-1:0]   core_result,
    output logic                 busy,
    output logic                 err
);

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;
    logic [KEY_MAX_W-1:0] w_key_next;

    state_t                 r_state;
    logic [8:0]             r_cnt;
    logic [HDR_KEEP-1:0]    r_hdr;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [BLOCK_W:0]       r_tx;
    logic [BLOCK_W-1:0]     r_data;
    logic [KEY_MAX_W-1:0]   r_key;
    logic                   r_miso, r_oe, r_start, r_enc, r_busy, r_err;
    logic [1:0]             r_nk;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .rst(rst), .i_async(sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .i_async(cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    // Same depth as the sclk path so mosi is sampled exactly with the detected edge.
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_key_next = {r_key[KEY_MAX_W-2:0], w_mosi};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hdr       <= '0;
            r_mosi_sync <= '0;
            r_tx        <= '0;
            r_data      <= '0;
            r_key       <= '0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
            r_start     <= 1'b0;
            r_enc       <= 1'b0;
            r_nk        <= NK4;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, mosi});
            r_start     <= 1'b0;
            if (w_cs_fall)
                r_oe <= 1'b1;
            else if (w_cs_rise)
                r_oe <= 1'b0;

            case (r_state)
                ST_IDLE: if (w_cs_fall) begin
                    r_state <= ST_HDR;
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_miso  <= 1'b0;
                end
                ST_HDR: if (w_cs_rise) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end else if (w_sclk_rise) begin
                    if (r_cnt < 9'(HDR_KEEP))
                        r_hdr <= {r_hdr[HDR_KEEP-2:0], w_mosi};
                    r_cnt <= r_cnt + 9'd1;
                    if (r_cnt == 9'(HDR_W - 1)) begin
                        r_cnt <= '0;
                        if (r_hdr[1:0] == NK_BAD) begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                            r_enc   <= r_hdr[HDR_KEEP-1];
                            r_nk    <= r_hdr[1:0];
                        end
                    end
                end
                ST_DATA: if (w_cs_rise) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end else if (w_sclk_rise) begin
                    r_data <= {r_data[BLOCK_W-2:0], w_mosi};
                    r_cnt  <= r_cnt + 9'd1;
                    if (r_cnt == 9'(BLOCK_W - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_KEY;
                    end
                end
                ST_KEY: if (w_cs_rise) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end else if (w_sclk_rise) begin
                    r_key <= w_key_next;
                    r_cnt <= r_cnt + 9'd1;
                    if (r_cnt == 9'(key_bits(r_nk) - 1)) begin
                        // Left-justify short keys so unused LSBs read as zero.
                        r_key   <= w_key_next << (KEY_MAX_W - key_bits(r_nk));
                        r_cnt   <= '0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_start <= 1'b1;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: if (core_done) begin
                    r_tx    <= {1'b1, core_result};
                    r_state <= w_cs_rise ? ST_IDLE : ST_SEND;
                    r_busy  <= ~w_cs_rise;
                end else if (w_cs_rise) begin
                    r_state <= ST_DRAIN;
                end else if (w_sclk_fall) begin
                    r_miso <= 1'b0;
                end
                ST_SEND: if (w_cs_rise) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_miso  <= 1'b0;
                end else if (w_sclk_fall) begin
                    r_miso <= r_tx[BLOCK_W];
                    r_tx   <= {r_tx[BLOCK_W-1:0], 1'b0};
                end
                ST_ERROR: if (w_cs_rise) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end else if (w_sclk_fall) begin
                    r_miso <= 1'b0;
                end
                ST_DRAIN: if (core_done) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign miso       = r_miso;
    assign miso_oe    = r_oe;
    assign core_start = r_start;
    assign core_enc   = r_enc;
    assign core_nk    = r_nk;
    assign core_data  = r_data;
    assign core_key   = r_key;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule
